// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// SERIAL_ADDER_SUB_EN (optional) adds a subtract-select port to serial_adder.
package serial_adder_pkg;

  localparam int SERIAL_ADDER_DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } serial_adder_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell: the only arithmetic element of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, one bit per clock LSB first, built on full_adder.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b via ~b and carry-in 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  serial_adder_state_t state;
  logic [WIDTH-1:0]    a_sr, b_sr, sum_sr;
  logic [CW-1:0]       cnt;
  logic                carry;
  logic                fa_sum, fa_carry;
  logic [WIDTH-1:0]    load_b;
  logic                load_c;
  logic [WIDTH-1:0]    next_sum;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so cin is replaced by a forced carry of 1.
  assign load_b = sub ? ~b : b;
  assign load_c = sub ? 1'b1 : cin;
`else
  assign load_b = b;
  assign load_c = cin;
`endif

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign next_sum = {fa_sum, sum_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= load_b;
            carry <= load_c;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= next_sum;
          carry  <= fa_carry;
          cnt    <= cnt + 1'b1;
          // The result registers are loaded together with the last bit.
          if (cnt == LAST) begin
            sum   <= next_sum;
            cout  <= fa_carry;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
